// File: rtl/nic8_pkg.sv
// Shared types, instruction-field constants and field helpers for the nic8 sequencer.
package nic8_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FETCH  = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALTED = 2'd3
   } seq_state_e;

   localparam logic [2:0] SRC_ROM   = 3'b000;
   localparam logic [2:0] DEST_HALT = 3'b111;

   // ir layout: {bit7, dest[2:0], bit3, source[2:0]}
   function automatic logic [2:0] ir_dest(input logic [7:0] ir);
      return ir[6:4];
   endfunction

   function automatic logic [2:0] ir_source(input logic [7:0] ir);
      return ir[2:0];
   endfunction

endpackage

// File: rtl/nic8_pc.sv
// Program counter: synchronous reset, increment enable, zero-extending load (load wins).
module nic8_pc #(
   parameter int PC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inc_en,
   input  logic                load_en,
   input  logic [7:0]          load_val,
   output logic [PC_WIDTH-1:0] pc
);

   logic [PC_WIDTH-1:0] pc_q, pc_d;

   always_comb begin
      pc_d = pc_q;
      if (load_en) begin
         pc_d = PC_WIDTH'(load_val);
      end else if (inc_en) begin
         pc_d = pc_q + PC_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= '0;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc = pc_q;

endmodule

// File: rtl/nic8_sequencer.sv
// nic8 fetch/execute sequencer: PC ownership, IR load strobe, exec gating, run/step/halt.
// Optional retired-instruction counter enabled by NIC8_SEQ_RETIRE_COUNT_EN.
module nic8_sequencer
   import nic8_pkg::*;
#(
   parameter int PC_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          ir,
   input  logic                doJumpBar,
   input  logic [7:0]          bus,
   input  logic                run,
   input  logic                step,
   output logic [PC_WIDTH-1:0] pc,
   output logic                loadIR,
   output logic                execEnable,
   output logic                halted
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
   ,
   output logic [15:0]         retired
`endif
);

   seq_state_e state_q, state_d;
   logic       pc_inc;
   logic       pc_load;
   logic       is_halt;
   logic       is_imm;

   assign is_halt = (ir_dest(ir) == DEST_HALT);
   assign is_imm  = (ir_source(ir) == SRC_ROM);

   always_comb begin
      state_d = state_q;
      pc_inc  = 1'b0;
      pc_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (run || step) begin
               state_d = ST_FETCH;
            end
         end
         ST_FETCH: begin
            pc_inc  = 1'b1;
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            // Halt freezes the PC even though its source field reads as ROM.
            if (is_halt) begin
               state_d = ST_HALTED;
            end else begin
               if (!doJumpBar) begin
                  pc_load = 1'b1;
               end else if (is_imm) begin
                  pc_inc = 1'b1;
               end
               state_d = run ? ST_FETCH : ST_IDLE;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   nic8_pc #(
      .PC_WIDTH(PC_WIDTH)
   ) u_pc (
      .clk      (clk),
      .reset    (reset),
      .inc_en   (pc_inc),
      .load_en  (pc_load),
      .load_val (bus),
      .pc       (pc)
   );

   assign loadIR     = (state_q == ST_FETCH);
   assign execEnable = (state_q == ST_EXEC);
   assign halted     = (state_q == ST_HALTED);

`ifdef NIC8_SEQ_RETIRE_COUNT_EN
   logic [15:0] retired_q, retired_d;

   always_comb begin
      retired_d = retired_q;
      if (state_q == ST_EXEC) begin
         retired_d = retired_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retired_q <= '0;
      end else begin
         retired_q <= retired_d;
      end
   end

   assign retired = retired_q;
`endif

endmodule

// File: tb/tb_nic8_sequencer.sv
// Directed bench for nic8_sequencer: fetch cadence, immediates, jumps, wrap, step, halt, reset.
module tb_nic8_sequencer;

   logic       clk;
   logic       reset;
   logic [7:0] ir;
   logic       doJumpBar;
   logic [7:0] bus;
   logic       run;
   logic       step;
   logic [7:0] pc;
   logic       loadIR;
   logic       execEnable;
   logic       halted;
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
   logic [15:0] retired;
`endif

   int checks_total;
   int checks_passed;
   int checks_failed;

   nic8_sequencer #(
      .PC_WIDTH(8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .ir         (ir),
      .doJumpBar  (doJumpBar),
      .bus        (bus),
      .run        (run),
      .step       (step),
      .pc         (pc),
      .loadIR     (loadIR),
      .execEnable (execEnable),
      .halted     (halted)
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
      ,
      .retired    (retired)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks_total++;
      assert (obs === exp) checks_passed++;
      else begin
         checks_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Checks loadIR, execEnable, halted and pc together.
   task automatic chk_st(input string tag, input logic l, input logic e, input logic h,
                         input logic [7:0] p);
      chk({tag, ".loadIR"}, {15'd0, loadIR}, {15'd0, l});
      chk({tag, ".execEnable"}, {15'd0, execEnable}, {15'd0, e});
      chk({tag, ".halted"}, {15'd0, halted}, {15'd0, h});
      chk({tag, ".pc"}, {8'd0, pc}, {8'd0, p});
   endtask

   initial begin
      checks_total  = 0;
      checks_passed = 0;
      checks_failed = 0;
      reset     = 1'b1;
      run       = 1'b1;
      step      = 1'b0;
      ir        = 8'h01;
      doJumpBar = 1'b1;
      bus       = 8'h00;
      tick();
      tick();
      chk_st("reset", 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
      chk("reset.retired", retired, 16'd0);
`endif

      // Free-run cadence over non-immediate, non-jump instructions
      reset = 1'b0;
      tick(); chk_st("c1", 1'b1, 1'b0, 1'b0, 8'h00);
      tick(); chk_st("c2", 1'b0, 1'b1, 1'b0, 8'h01);
      tick(); chk_st("c3", 1'b1, 1'b0, 1'b0, 8'h01);
      tick(); chk_st("c4", 1'b0, 1'b1, 1'b0, 8'h02);
      tick(); chk_st("c5", 1'b1, 1'b0, 1'b0, 8'h02);
      tick(); chk_st("c6", 1'b0, 1'b1, 1'b0, 8'h03);
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
      chk("c6.retired", retired, 16'd2);
`endif

      // Jump to 0x10, then immediate load there
      doJumpBar = 1'b0; bus = 8'h10;
      tick(); chk_st("jmp10", 1'b1, 1'b0, 1'b0, 8'h10);
      doJumpBar = 1'b1; ir = 8'h20;
      tick(); chk_st("imm.exec", 1'b0, 1'b1, 1'b0, 8'h11);
      tick(); chk_st("imm.next", 1'b1, 1'b0, 1'b0, 8'h12);

      // Reach 0xFE, then immediate-operand jump to 0x40
      ir = 8'h01;
      tick(); chk_st("to_fe.exec", 1'b0, 1'b1, 1'b0, 8'h13);
      doJumpBar = 1'b0; bus = 8'hFE;
      tick(); chk_st("fe.fetch", 1'b1, 1'b0, 1'b0, 8'hFE);
      doJumpBar = 1'b1; ir = 8'h10;
      tick(); chk_st("fe.exec", 1'b0, 1'b1, 1'b0, 8'hFF);
      doJumpBar = 1'b0; bus = 8'h40;
      tick(); chk_st("jmp40", 1'b1, 1'b0, 1'b0, 8'h40);

      // PC wrap from 0xFF
      doJumpBar = 1'b1; ir = 8'h01;
      tick(); chk_st("to_ff.exec", 1'b0, 1'b1, 1'b0, 8'h41);
      doJumpBar = 1'b0; bus = 8'hFF;
      tick(); chk_st("ff.fetch", 1'b1, 1'b0, 1'b0, 8'hFF);
      doJumpBar = 1'b1; ir = 8'h01;
      tick(); chk_st("wrap.exec", 1'b0, 1'b1, 1'b0, 8'h00);
      tick(); chk_st("wrap.fetch", 1'b1, 1'b0, 1'b0, 8'h00);

      // Clearing run during FETCH still completes EXEC, then pauses
      run = 1'b0;
      tick(); chk_st("pause.exec", 1'b0, 1'b1, 1'b0, 8'h01);
      tick(); chk_st("pause.idle", 1'b0, 1'b0, 1'b0, 8'h01);
      tick(); chk_st("pause.hold", 1'b0, 1'b0, 1'b0, 8'h01);

      // Single step; a pulse during EXEC is ignored and not queued
      step = 1'b1;
      tick(); chk_st("step.fetch", 1'b1, 1'b0, 1'b0, 8'h01);
      step = 1'b0;
      tick(); chk_st("step.exec", 1'b0, 1'b1, 1'b0, 8'h02);
      step = 1'b1;
      tick(); chk_st("step.idle", 1'b0, 1'b0, 1'b0, 8'h02);
      step = 1'b0;
      tick(); chk_st("step.noqueue", 1'b0, 1'b0, 1'b0, 8'h02);

      // Halt (source field reads ROM, but PC must stay frozen)
      run = 1'b1; ir = 8'h70;
      tick(); chk_st("halt.fetch", 1'b1, 1'b0, 1'b0, 8'h02);
      tick(); chk_st("halt.exec", 1'b0, 1'b1, 1'b0, 8'h03);
      tick(); chk_st("halt.state", 1'b0, 1'b0, 1'b1, 8'h03);
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
      chk("halt.retired", retired, 16'd11);
`endif
      run = 1'b0; step = 1'b1;
      tick(); chk_st("halt.ignore1", 1'b0, 1'b0, 1'b1, 8'h03);
      run = 1'b1; step = 1'b0;
      tick(); chk_st("halt.ignore2", 1'b0, 1'b0, 1'b1, 8'h03);
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
      chk("halt.retired_hold", retired, 16'd11);
`endif

      // Reset leaves HALTED
      reset = 1'b1; run = 1'b0;
      tick(); chk_st("rst2", 1'b0, 1'b0, 1'b0, 8'h00);
`ifdef NIC8_SEQ_RETIRE_COUNT_EN
      chk("rst2.retired", retired, 16'd0);
`endif
      reset = 1'b0;
      tick(); chk_st("rst2.idle", 1'b0, 1'b0, 1'b0, 8'h00);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
